seg_msg_scanner: RTL

Parametrised multiplexed 7-segment message controller for the coffee-machine front panel. It selects one 4-character status word from the drink-selection, sensor-error and validation inputs by fixed priority. It latches that word once per scan frame and time-multiplexes it across `NUM_DIGITS` common digits. Error words blink, and a lamp-test mode lights every segment.

---
 rtl/seg_msg_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seg_msg_scanner.sv
// Multiplexed 7-segment status-word scanner for the coffee-machine front panel.
//
// A 4-character word is chosen by fixed priority from the lamp-test, sensor, validation and
// drink-selection inputs. It is latched once per scan frame, so a frame is never torn, and then
// time-multiplexed across NUM_DIGITS common digits. Digit 0 is rightmost, and digits 4 and up
// are blank.
//
// Optional feature: define DISP_BLINK_EN to make error words (ERSR/ERSP/ERSN/ERDI) blink with a
// half-period of BLINK_FRAMES frames. When it is undefined, error words are steady.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   S[3:0]       drink selection (lowest set bit wins)
//   SR, SP, SN   sensor error flags
//   VL           money-validation error
//   M            lamp test (all segments on)
//   seg[6:0]     active-high segments, seg[6]=a .. seg[0]=g
//   an           one-hot active-high digit enable
//   frame_start  one-cycle pulse on the first cycle of digit 0 of each frame
module seg_msg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            S,
    input  logic                  SR,
    input  logic                  SP,
    input  logic                  SN,
    input  logic                  VL,
    input  logic                  M,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PreW = $clog2(SCAN_DIV);

    // Character codes. A word packs character i at bits [4*i +: 4], with character 0 rightmost.
    localparam logic [3:0] Ch0 = 4'd0,  Ch1 = 4'd1,  Ch2 = 4'd2,  Ch5 = 4'd3;
    localparam logic [3:0] Ch8 = 4'd4,  ChC = 4'd5,  ChE = 4'd6,  ChL = 4'd7;
    localparam logic [3:0] ChP = 4'd8,  ChR = 4'd9,  ChS = 4'd10, ChN = 4'd11;
    localparam logic [3:0] ChD = 4'd12, ChI = 4'd13, ChDash = 4'd14, ChBlank = 4'd15;

    localparam logic [15:0] WordIdle = {ChDash, ChDash, ChDash, ChDash};
    localparam logic [15:0] WordErsr = {ChE, ChR, ChS, ChR};
    localparam logic [15:0] WordErsp = {ChE, ChR, ChS, ChP};
    localparam logic [15:0] WordErsn = {ChE, ChR, ChS, ChN};
    localparam logic [15:0] WordErdi = {ChE, ChR, ChD, ChI};

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            Ch0:     g = 7'b1111110;
            Ch1:     g = 7'b0110000;
            Ch2:     g = 7'b1101101;
            Ch5:     g = 7'b1011011;
            Ch8:     g = 7'b1111111;
            ChC:     g = 7'b1001110;
            ChE:     g = 7'b1001111;
            ChL:     g = 7'b0001110;
            ChP:     g = 7'b1100111;
            ChR:     g = 7'b0000101;
            ChS:     g = 7'b1011011;
            ChN:     g = 7'b0010101;
            ChD:     g = 7'b0111101;
            ChI:     g = 7'b0110000;
            ChDash:  g = 7'b0000001;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    logic [PreW-1:0]       presc_q, presc_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [15:0]           msg_q, msg_d;
    logic                  wrapped_q, wrapped_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q;
    logic [15:0]           sel_word;
    logic                  slot_end, frame_wrap, blank_now;
    logic [3:0]            idx_w;
    logic [3:0]            cur_char;

    // Priority word selection.
    always_comb begin
        sel_word = WordIdle;
        if (M)         sel_word = {Ch8, Ch8, Ch8, Ch8};
        else if (SR)   sel_word = WordErsr;
        else if (SP)   sel_word = WordErsp;
        else if (SN)   sel_word = WordErsn;
        else if (VL)   sel_word = WordErdi;
        else if (S[0]) sel_word = {ChC, ChE, Ch0, Ch1};
        else if (S[1]) sel_word = {ChC, ChL, Ch0, Ch2};
        else if (S[2]) sel_word = {ChC, ChC, Ch0, Ch5};
        else if (S[3]) sel_word = {ChC, ChP, Ch1, Ch0};
    end

    // Prescaler, digit index and frame latch.
    always_comb begin
        slot_end   = (presc_q == PreW'(SCAN_DIV - 1));
        frame_wrap = slot_end && (idx_q == IdxW'(NUM_DIGITS - 1));
        presc_d    = slot_end ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (slot_end) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
        msg_d      = frame_wrap ? sel_word : msg_q;
        // frame_start is output one cycle after the wrap, alongside the first glyph of the word.
        wrapped_d  = frame_wrap;
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic logic is_err(input logic [15:0] w);
        return (w == WordErsr) || (w == WordErsp) || (w == WordErsn) || (w == WordErdi);
    endfunction

    logic [BlkW-1:0] cnt_q, cnt_d;
    logic            lit_q, lit_d;

    // A class change restarts the blink, so a fresh error always starts lit.
    always_comb begin
        cnt_d = cnt_q;
        lit_d = lit_q;
        if (frame_wrap) begin
            if (is_err(sel_word) != is_err(msg_q)) begin
                cnt_d = '0;
                lit_d = 1'b1;
            end else if (is_err(sel_word)) begin
                if (32'(cnt_q) + 32'd1 >= BLINK_FRAMES) begin
                    cnt_d = '0;
                    lit_d = ~lit_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        blank_now = ~lit_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            lit_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            lit_q <= lit_d;
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES == 0);
    assign blank_now        = 1'b0;
`endif

    // Output stage: render the current index and latched word for the next cycle.
    always_comb begin
        idx_w    = 4'(idx_q);
        cur_char = (idx_w < 4'd4) ? msg_q[{idx_w[1:0], 2'b00} +: 4] : ChBlank;
        seg_d    = blank_now ? 7'b0000000 : glyph(cur_char);
        an_d     = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q   <= '0;
            idx_q     <= '0;
            msg_q     <= WordIdle;
            wrapped_q <= 1'b0;
            seg_q     <= 7'b0000001;
            an_q      <= NUM_DIGITS'(1);
            fs_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            msg_q     <= msg_d;
            wrapped_q <= wrapped_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fs_q      <= wrapped_q;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule
